// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and integer-to-packed-BCD helpers
package bcd_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;
  function automatic logic [31:0] to_bcd(input int unsigned v);
    int unsigned rem;
    to_bcd = '0;
    rem = v;
    for (int i = 0; i < 8; i++) begin
      to_bcd[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
  endfunction
  function automatic int unsigned pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit with load, up/down step and ripple carry/borrow out
module bcd_digit
  import bcd_pkg::*;
#(
  parameter bcd_t RST_D = BCD_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  input  logic up_dn,
  input  logic load,
  input  bcd_t load_d,
  output bcd_t d,
  output logic carry_out
);
  assign carry_out = en_in & (d == (up_dn ? BCD_MAX : BCD_MIN));
  always_ff @(posedge clk or posedge rst)
    if (rst) d <= RST_D;
    else if (load) d <= load_d;
    else if (en_in) d <= up_dn ? (d == BCD_MAX ? BCD_MIN : d + 4'd1)
                               : (d == BCD_MIN ? BCD_MAX : d - 4'd1);
endmodule

// File: rtl/multi_digit_bcd_counter.sv
// multi_digit_bcd_counter: NDIGITS-digit up/down BCD counter with checked load and tc/zero flags.
// Define BCD_CNT_SATURATE_EN to stop at all-9s/all-0s instead of wrapping.
module multi_digit_bcd_counter
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4,
  parameter int RST_VAL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   up_dn,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   cnt,
  output logic                   tc,
  output logic                   zero,
  output logic                   load_err
);
  localparam int W = 4*NDIGITS;
  localparam logic [31:0] RST_BCD = to_bcd(RST_VAL);
  localparam logic [31:0] ALL9_BCD = to_bcd(pow10(NDIGITS) - 1);
  localparam logic [W-1:0] ALL9 = ALL9_BCD[W-1:0];
  localparam logic [W-1:0] ONE = W'(1);
`ifdef BCD_CNT_SATURATE_EN
  localparam logic [31:0] NEAR9_BCD = to_bcd(pow10(NDIGITS) - 2);
  localparam logic [W-1:0] NEAR9 = NEAR9_BCD[W-1:0];
`endif
  logic w_load_ok, w_en0, w_tc_nxt, w_zero_nxt;
  logic [NDIGITS:0] w_carry;
  logic r_tc, r_zero, r_load_err;
  always_comb begin
    w_load_ok = load;
    for (int i = 0; i < NDIGITS; i++)
      if (load_val[4*i +: 4] > BCD_MAX) w_load_ok = 1'b0;
  end
`ifdef BCD_CNT_SATURATE_EN
  // stepping is blocked at the terminal value; tc marks the step that lands on it
  assign w_en0 = en & ~load & (cnt != (up_dn ? ALL9 : '0));
  assign w_tc_nxt = w_carry[NDIGITS] | (w_en0 & (cnt == (up_dn ? NEAR9 : ONE)));
`else
  assign w_en0 = en & ~load;
  assign w_tc_nxt = w_carry[NDIGITS];
`endif
  assign w_carry[0] = w_en0;
  assign w_zero_nxt = w_load_ok ? (load_val == '0)
                    : w_en0 ? (cnt == (up_dn ? ALL9 : ONE))
                    : (cnt == '0);
  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    bcd_digit #(.RST_D(RST_BCD[4*g +: 4])) u_digit (
      .clk       (clk),
      .rst       (rst),
      .en_in     (w_carry[g]),
      .up_dn     (up_dn),
      .load      (w_load_ok),
      .load_d    (load_val[4*g +: 4]),
      .d         (cnt[4*g +: 4]),
      .carry_out (w_carry[g+1])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tc <= 1'b0;
      r_zero <= (RST_VAL == 0);
      r_load_err <= 1'b0;
    end else begin
      r_tc <= w_tc_nxt;
      r_zero <= w_zero_nxt;
      r_load_err <= load & ~w_load_ok;
    end
  assign tc = r_tc;
  assign zero = r_zero;
  assign load_err = r_load_err;
endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// tb_multi_digit_bcd_counter: decimal-integer reference model checked every cycle plus directed literal checks
module tb_multi_digit_bcd_counter;
  logic clk = 0, rst = 0, en = 0, up_dn = 1, load = 0;
  logic [15:0] load_val = '0;
  logic [15:0] cnt;
  logic tc, zero, load_err;
  int checks = 0, errors = 0;
  int m_val = 42;
  logic m_tc = 0, m_err = 0;
  int tcs, tc_at;
  logic [15:0] held;

  multi_digit_bcd_counter #(.NDIGITS(4), .RST_VAL(42)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .cnt(cnt), .tc(tc), .zero(zero), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd16(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  function automatic bit is_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction
  function automatic int bcd_val(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int v;
    logic t, e;
    v = m_val; t = 0; e = 0;
    if (rst) v = 42;
    else if (load) begin
      if (is_bcd(load_val)) v = bcd_val(load_val);
      else e = 1;
    end else if (en) begin
`ifdef BCD_CNT_SATURATE_EN
      if (up_dn && v < 9999) begin v = v + 1; t = (v == 9999); end
      else if (!up_dn && v > 0) begin v = v - 1; t = (v == 0); end
`else
      if (up_dn) begin v = (v + 1) % 10000; t = (v == 0); end
      else begin v = (v + 9999) % 10000; t = (v == 9999); end
`endif
    end
    m_val <= v; m_tc <= t; m_err <= e;
  end

  always @(negedge clk) begin
    chk("model_cnt", cnt, to_bcd16(m_val));
    chk("model_tc", 16'(tc), 16'(m_tc));
    chk("model_zero", 16'(zero), 16'(m_val == 0));
    chk("model_load_err", 16'(load_err), 16'(m_err));
  end

  task automatic step(input logic l, input logic [15:0] lv, input logic e, input logic u);
    @(negedge clk);
    #1;
    load = l; load_val = lv; en = e; up_dn = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 rst = 1;
    #1;
    chk("reset_cnt", cnt, 16'h0042);
    chk("reset_zero", 16'(zero), 16'h0);
    chk("reset_tc", 16'(tc), 16'h0);
    chk("reset_err", 16'(load_err), 16'h0);
    @(negedge clk);
    #1 rst = 0;
    step(1, 16'h0000, 0, 1);
    chk("load0_cnt", cnt, 16'h0000);
    chk("load0_zero", 16'(zero), 16'h1);
    tcs = 0; tc_at = -1;
    for (int i = 0; i < 10000; i++) begin
      step(0, 16'h0000, 1, 1);
      if (tc) begin tcs++; tc_at = bcd_val(cnt); end
    end
    chk("full_up_tc_count", 16'(tcs), 16'd1);
`ifdef BCD_CNT_SATURATE_EN
    chk("full_up_tc_at", 16'(tc_at), 16'd9999);
    chk("full_up_end", cnt, 16'h9999);
`else
    chk("full_up_tc_at", 16'(tc_at), 16'd0);
    chk("full_up_end", cnt, 16'h0000);
`endif
    step(1, 16'h0100, 0, 1);
    chk("load0100", cnt, 16'h0100);
    step(0, 16'h0000, 1, 0);
    chk("borrow_0099", cnt, 16'h0099);
    repeat (99) step(0, 16'h0000, 1, 0);
    chk("down_to_zero", cnt, 16'h0000);
    chk("down_zero_flag", 16'(zero), 16'h1);
`ifdef BCD_CNT_SATURATE_EN
    chk("down_zero_tc", 16'(tc), 16'h1);
    step(0, 16'h0000, 1, 0);
    chk("sat_low_hold", cnt, 16'h0000);
    chk("sat_low_tc", 16'(tc), 16'h0);
`else
    chk("down_zero_tc", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 0);
    chk("wrap_9999", cnt, 16'h9999);
    chk("wrap_tc", 16'(tc), 16'h1);
`endif
    held = cnt;
    step(1, 16'h12A4, 0, 0);
    chk("bad_load_hold", cnt, held);
    chk("bad_load_err", 16'(load_err), 16'h1);
    step(0, 16'h0000, 0, 0);
    chk("bad_load_err_clear", 16'(load_err), 16'h0);
    chk("idle_hold", cnt, held);
    step(1, 16'h0005, 1, 1);
    chk("load_over_en", cnt, 16'h0005);
    chk("load_tc0", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 1);
    chk("up_6", cnt, 16'h0006);
    step(0, 16'h0000, 1, 0);
    chk("dir_change_5", cnt, 16'h0005);
    step(1, 16'h9998, 0, 1);
    chk("load9998", cnt, 16'h9998);
`ifdef BCD_CNT_SATURATE_EN
    step(0, 16'h0000, 1, 1);
    chk("sat_up1", cnt, 16'h9999); chk("sat_up1_tc", 16'(tc), 16'h1);
    step(0, 16'h0000, 1, 1);
    chk("sat_up2", cnt, 16'h9999); chk("sat_up2_tc", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 1);
    chk("sat_up3", cnt, 16'h9999); chk("sat_up3_tc", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 0);
    chk("sat_reverse", cnt, 16'h9998);
`else
    step(0, 16'h0000, 1, 1);
    chk("up1", cnt, 16'h9999); chk("up1_tc", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 1);
    chk("up2", cnt, 16'h0000); chk("up2_tc", 16'(tc), 16'h1);
    step(0, 16'h0000, 1, 1);
    chk("up3", cnt, 16'h0001); chk("up3_tc", 16'(tc), 16'h0);
    step(0, 16'h0000, 1, 0);
    chk("reverse", cnt, 16'h0000);
`endif
    step(1, 16'h0457, 0, 1);
    chk("load0457", cnt, 16'h0457);
    step(1, 16'h00F0, 1, 1);
    chk("pre_rst_err", 16'(load_err), 16'h1);
    @(negedge clk);
    #2;
    load_val = 16'h0777;
    rst = 1;
    #1;
    chk("async_rst_cnt", cnt, 16'h0042);
    chk("async_rst_tc", 16'(tc), 16'h0);
    chk("async_rst_err", 16'(load_err), 16'h0);
    chk("async_rst_zero", 16'(zero), 16'h0);
    @(posedge clk);
    #1;
    chk("rst_held_cnt", cnt, 16'h0042);
    @(negedge clk);
    #1;
    rst = 0; load = 0; en = 1; up_dn = 1;
    @(posedge clk);
    #1;
    chk("post_rst_step", cnt, 16'h0043);
    step(0, 16'h0000, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
